text_overlay_ctrl: RTL and testbench
====================================

// Module: text_overlay_ctrl
// PURPOSE
//  Downstream consumer of the bitmap text generators (title banner, "RESETTING" banner) in the VGA path.
//  Composites their 'on' bits over the board RGB stream and sequences which banner is visible.
//  Sequencing uses a frame-synchronous FSM: TITLE -> PLAY -> RESET -> PLAY.
//  Drives the final registered 12-bit RGB to the VGA pins; sits between the pixel generators and the DAC.
// PARAMETERS
//  BLINK_FRAMES  16   frames per half-period of RESETTING blink (1..255)
//  MIN_FRAMES    60   minimum frames RESET banner is held (1..255)
//  FRAME_LINE    480  pixel_y at which the frame strobe fires (first vblank line)
//  TEXT_RGB      12'hFF0  text colour; BG_RGB 12'h000 background colour
// PORTS
//  clk           in   1   system clock
//  reset_n       in   1   async active-low reset
//  pixel_tick    in   1   pixel enable (one clk per pixel)
//  video_on      in   1   visible-area flag from sync generator
//  pixel_x       in   10  current column
//  pixel_y       in   10  current row
//  board_rgb     in   12  board graphics colour for current pixel
//  title_on      in   1   title text bit for current pixel
//  resetting_on  in   1   RESETTING text bit for current pixel
//  start_btn     in   1   one-clk pulse: leave title screen
//  reset_req     in   1   one-clk pulse: board regeneration requested
//  board_ready   in   1   level: regenerated board valid
//  rgb           out  12  registered output colour
//  state_o       out  2   current FSM state (TITLE=0, PLAY=1, RESET=2)
//  reset_busy    out  1   high while state_o==RESET
// BEHAVIOUR
//  - Reset (async, reset_n=0): state=TITLE, rgb=0, pending flags=0, frame/blink counters=0, blink phase=on.
//  - frame_stb = pixel_tick & pixel_x==0 & pixel_y==FRAME_LINE; exactly one clk per frame.
//  - start_btn/reset_req latch into pending flags on any clk; FSM acts only on frame_stb (no tearing).
//  - TITLE: frame_stb & start_pend -> PLAY, clear start_pend. reset_pend ignored and cleared.
//  - PLAY: frame_stb & reset_pend -> RESET; clear reset_pend, frame_cnt=0, blink_cnt=0, phase=on.
//  - RESET: per frame_stb frame_cnt++ (saturate 255); blink_cnt++, at BLINK_FRAMES-1 wrap to 0 and toggle phase.
//    Exit to PLAY on frame_stb when board_ready=1 AND frame_cnt>=MIN_FRAMES-1. reset_req in RESET is re-latched
//    and restarts frame_cnt at the next frame_stb (stay in RESET). start_btn outside TITLE ignored and cleared.
//  - Simultaneous start_btn and reset_req in TITLE: start wins, reset dropped.
//  - Pixel select (registered, 1 clk latency from inputs, evaluated every clk):
//    video_on=0 -> 0; TITLE -> title_on?TEXT_RGB:BG_RGB; PLAY -> board_rgb;
//    RESET -> (resetting_on & phase)?TEXT_RGB:{1'b0,board_rgb[11:9],1'b0,board_rgb[7:5],1'b0,board_rgb[3:1]} (board halved).
//  - reset_n low mid-frame: immediate return to reset values; first output after release is TITLE composition.
// CONFIGURATION
//  TEXT_SHADOW_EN defined: 1-pixel drop shadow; prev_on register (title_on|resetting_on as displayed),
//   updated on pixel_tick, cleared when pixel_x==0. Pixel with prev_on=1 & own text bit=0 outputs 12'h444
//   instead of background/board. Not defined: no shadow logic, prev_on absent, outputs as above.
// STRUCTURE
//  Package text_overlay_pkg: state encoding localparams (ST_TITLE/ST_PLAY/ST_RESET), SHADOW_RGB, colour width 12.
//  Sub-module frame_timer: frame_stb generation plus frame_cnt/blink_cnt/phase; FSM and mux stay in top.
// TESTING
//  - Reset asserted, then released: rgb=0, state_o=0; pixel with title_on=1, video_on=1 -> rgb=12'hFF0 next clk.
//  - start_btn pulse mid-frame: state_o stays 0 until frame_stb, becomes 1 the clk after; board_rgb=12'h123 passes.
//  - reset_req in PLAY, board_ready=1 immediately: state_o=2 for exactly MIN_FRAMES(60) frame strobes, then 1.
//  - RESET, resetting_on=1: rgb alternates 12'hFF0 / halved board every 16 frames; board_rgb=12'hEEE halves to 12'h777.
//  - video_on=0 in any state -> rgb=0; simultaneous start_btn+reset_req in TITLE -> PLAY, not RESET.
//  - TEXT_SHADOW_EN: text bit at x=100 only -> x=101 outputs 12'h444; without macro x=101 outputs BG/board.

Source files
------------

// File: rtl/text_overlay_pkg.sv
`default_nettype none
// ============================================================================
// Module      : text_overlay_pkg
// Description : Shared state encoding, colour width and colour helpers for
//               the VGA text-overlay compositor.
// Revision    : 1.0 - initial release
// ============================================================================
package text_overlay_pkg;

    localparam int RGB_W = 12;

    typedef logic [1:0] state_t;

    localparam state_t ST_TITLE = 2'd0;
    localparam state_t ST_PLAY  = 2'd1;
    localparam state_t ST_RESET = 2'd2;

    localparam logic [RGB_W-1:0] SHADOW_RGB = 12'h444;

    // Dim a colour by dropping one bit from each 4-bit channel.
    function automatic logic [RGB_W-1:0] halve_rgb(input logic [RGB_W-1:0] c);
        return {1'b0, c[11:9], 1'b0, c[7:5], 1'b0, c[3:1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/text_overlay_ctrl_frame_timer.sv
`default_nettype none
// ============================================================================
// Module      : frame_timer
// Description : Frame strobe generation plus the frame counter, blink counter
//               and blink phase used while the RESETTING banner is shown.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_timer #(
    parameter int BLINK_FRAMES = 16,
    parameter int FRAME_LINE   = 480
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pixel_tick,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       timer_clear,
    input  logic       timer_step,
    input  logic       frame_restart,
    output logic       frame_stb,
    output logic [7:0] frame_cnt,
    output logic       blink_phase
);

    localparam logic [9:0] C_FRAME_LINE = 10'(FRAME_LINE);
    localparam logic [7:0] C_BLINK_LAST = 8'(BLINK_FRAMES - 1);

    logic [7:0] r_frame_cnt;
    logic [7:0] r_blink_cnt;
    logic       r_phase;

    assign frame_stb   = pixel_tick & (pixel_x == 10'd0) & (pixel_y == C_FRAME_LINE);
    assign frame_cnt   = r_frame_cnt;
    assign blink_phase = r_phase;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_cnt <= 8'd0;
            r_blink_cnt <= 8'd0;
            r_phase     <= 1'b1;
        end else if (timer_clear) begin
            r_frame_cnt <= 8'd0;
            r_blink_cnt <= 8'd0;
            r_phase     <= 1'b1;
        end else if (timer_step) begin
            // A re-requested reset restarts the hold time but not the blink cadence.
            if (frame_restart)
                r_frame_cnt <= 8'd0;
            else if (r_frame_cnt != 8'hFF)
                r_frame_cnt <= r_frame_cnt + 8'd1;

            if (r_blink_cnt == C_BLINK_LAST) begin
                r_blink_cnt <= 8'd0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/text_overlay_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : text_overlay_ctrl
// Description : Composites title / RESETTING banners over the board RGB stream
//               and sequences banner visibility on frame boundaries.
//               Optional macro TEXT_SHADOW_EN adds a 1-pixel text drop shadow.
// Revision    : 1.0 - initial release
// ============================================================================
module text_overlay_ctrl
    import text_overlay_pkg::*;
#(
    parameter int               BLINK_FRAMES = 16,
    parameter int               MIN_FRAMES   = 60,
    parameter int               FRAME_LINE   = 480,
    parameter logic [RGB_W-1:0] TEXT_RGB     = 12'hFF0,
    parameter logic [RGB_W-1:0] BG_RGB       = 12'h000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pixel_tick,
    input  logic             video_on,
    input  logic [9:0]       pixel_x,
    input  logic [9:0]       pixel_y,
    input  logic [RGB_W-1:0] board_rgb,
    input  logic             title_on,
    input  logic             resetting_on,
    input  logic             start_btn,
    input  logic             reset_req,
    input  logic             board_ready,
    output logic [RGB_W-1:0] rgb,
    output logic [1:0]       state_o,
    output logic             reset_busy
);

    localparam logic [7:0] C_MIN_LAST = 8'(MIN_FRAMES - 1);

    state_t           r_state;
    logic             r_busy;
    logic             r_start_pend;
    logic             r_reset_pend;
    logic [RGB_W-1:0] r_rgb;

    logic             w_frame_stb;
    logic [7:0]       w_frame_cnt;
    logic             w_phase;
    logic             w_start_any;
    logic             w_reset_any;
    logic             w_min_met;
    logic             w_timer_clear;
    logic             w_timer_step;
    logic             w_text_bit;
    logic [RGB_W-1:0] w_base;
    logic [RGB_W-1:0] w_pix;

    // A pulse arriving on the strobe clock itself counts as already pending.
    assign w_start_any   = r_start_pend | start_btn;
    assign w_reset_any   = r_reset_pend | reset_req;
    assign w_min_met     = (w_frame_cnt >= C_MIN_LAST);
    assign w_timer_clear = w_frame_stb & (r_state == ST_PLAY) & w_reset_any;
    assign w_timer_step  = w_frame_stb & (r_state == ST_RESET);

    frame_timer #(
        .BLINK_FRAMES (BLINK_FRAMES),
        .FRAME_LINE   (FRAME_LINE)
    ) u_frame_timer (
        .clk           (clk),
        .reset_n       (reset_n),
        .pixel_tick    (pixel_tick),
        .pixel_x       (pixel_x),
        .pixel_y       (pixel_y),
        .timer_clear   (w_timer_clear),
        .timer_step    (w_timer_step),
        .frame_restart (w_reset_any),
        .frame_stb     (w_frame_stb),
        .frame_cnt     (w_frame_cnt),
        .blink_phase   (w_phase)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_TITLE;
            r_busy       <= 1'b0;
            r_start_pend <= 1'b0;
            r_reset_pend <= 1'b0;
        end else begin
            case (r_state)
                ST_TITLE: begin
                    r_reset_pend <= 1'b0;
                    if (w_frame_stb && w_start_any) begin
                        r_state      <= ST_PLAY;
                        r_start_pend <= 1'b0;
                    end else if (start_btn) begin
                        r_start_pend <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    r_start_pend <= 1'b0;
                    if (w_frame_stb && w_reset_any) begin
                        r_state      <= ST_RESET;
                        r_busy       <= 1'b1;
                        r_reset_pend <= 1'b0;
                    end else if (reset_req) begin
                        r_reset_pend <= 1'b1;
                    end
                end
                ST_RESET: begin
                    r_start_pend <= 1'b0;
                    if (w_frame_stb) begin
                        r_reset_pend <= 1'b0;
                        if (!w_reset_any && board_ready && w_min_met) begin
                            r_state <= ST_PLAY;
                            r_busy  <= 1'b0;
                        end
                    end else if (reset_req) begin
                        r_reset_pend <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= ST_TITLE;
                    r_busy       <= 1'b0;
                    r_start_pend <= 1'b0;
                    r_reset_pend <= 1'b0;
                end
            endcase
        end
    end

`ifdef TEXT_SHADOW_EN
    logic r_prev_on;
    logic w_prev_eff;

    // The left edge never inherits a shadow from the previous line.
    assign w_prev_eff = r_prev_on & (pixel_x != 10'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_prev_on <= 1'b0;
        else if (pixel_tick)
            r_prev_on <= w_text_bit & video_on;
    end
`endif

    always_comb begin
        w_text_bit = 1'b0;
        w_base     = BG_RGB;
        case (r_state)
            ST_TITLE: begin
                w_text_bit = title_on;
                w_base     = BG_RGB;
            end
            ST_PLAY: begin
                w_base     = board_rgb;
            end
            ST_RESET: begin
                w_text_bit = resetting_on & w_phase;
                w_base     = halve_rgb(board_rgb);
            end
            default: begin
                w_base     = BG_RGB;
            end
        endcase

        w_pix = w_text_bit ? TEXT_RGB : w_base;
`ifdef TEXT_SHADOW_EN
        if (!w_text_bit && w_prev_eff)
            w_pix = SHADOW_RGB;
`endif
        if (!video_on)
            w_pix = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_rgb <= '0;
        else
            r_rgb <= w_pix;
    end

    assign rgb        = r_rgb;
    assign state_o    = r_state;
    assign reset_busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_text_overlay_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_text_overlay_ctrl
// Description : Scoreboard bench for text_overlay_ctrl; stimulus pushes the
//               expected rgb/state per clock, a monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_text_overlay_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pixel_tick;
    logic        video_on;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic [11:0] board_rgb;
    logic        title_on;
    logic        resetting_on;
    logic        start_btn;
    logic        reset_req;
    logic        board_ready;
    logic [11:0] rgb;
    logic [1:0]  state_o;
    logic        reset_busy;

`ifdef TEXT_SHADOW_EN
    localparam logic [11:0] EXP_SHADOW = 12'h444;
`else
    localparam logic [11:0] EXP_SHADOW = 12'h000;
`endif

    int          cyc   = 0;
    int          total = 0;
    int          bad   = 0;
    int          q_due[$];
    logic [14:0] q_val[$];
    string       q_nm[$];

    text_overlay_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pixel_tick   (pixel_tick),
        .video_on     (video_on),
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .board_rgb    (board_rgb),
        .title_on     (title_on),
        .resetting_on (resetting_on),
        .start_btn    (start_btn),
        .reset_req    (reset_req),
        .board_ready  (board_ready),
        .rgb          (rgb),
        .state_o      (state_o),
        .reset_busy   (reset_busy)
    );

    always #5 clk = ~clk;

    // Monitor: after every rising edge, compare any expectation that is due.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc = cyc + 1;
            while (q_due.size() > 0 && q_due[0] <= cyc) begin
                logic [14:0] e;
                string       nm;
                e  = q_val.pop_front();
                nm = q_nm.pop_front();
                void'(q_due.pop_front());
                total = total + 1;
                if (rgb !== e[11:0] || state_o !== e[13:12] || reset_busy !== e[14]) begin
                    bad = bad + 1;
                    $display("FAIL %s: got rgb=%h state=%0d busy=%b, want rgb=%h state=%0d busy=%b",
                             nm, rgb, state_o, reset_busy, e[11:0], e[13:12], e[14]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // Inputs are already set; queue the expectation for the coming edge.
    task automatic step(input logic [11:0] erg, input logic [1:0] est, input string nm);
        q_due.push_back(cyc + 1);
        q_val.push_back({(est == 2'd2), est, erg});
        q_nm.push_back(nm);
        @(negedge clk);
        start_btn = 1'b0;
        reset_req = 1'b0;
        pixel_x   = 10'd5;
        pixel_y   = 10'd10;
    endtask

    task automatic frame(input logic [11:0] erg, input logic [1:0] est, input string nm);
        pixel_x = 10'd0;
        pixel_y = 10'd480;
        step(erg, est, nm);
    endtask

    initial begin
        reset_n      = 1'b0;
        pixel_tick   = 1'b1;
        video_on     = 1'b1;
        pixel_x      = 10'd5;
        pixel_y      = 10'd10;
        board_rgb    = 12'h000;
        title_on     = 1'b1;
        resetting_on = 1'b0;
        start_btn    = 1'b0;
        reset_req    = 1'b0;
        board_ready  = 1'b0;
        @(negedge clk);

        step(12'h000, 2'd0, "rst_hold0");
        step(12'h000, 2'd0, "rst_hold1");
        reset_n = 1'b1;

        step(12'hFF0, 2'd0, "title_text");
        title_on = 1'b0;
        step(12'h000, 2'd0, "title_bg");
        video_on = 1'b0; title_on = 1'b1;
        step(12'h000, 2'd0, "title_vid_off");
        video_on = 1'b1;

        pixel_x = 10'd100; title_on = 1'b1;
        step(12'hFF0, 2'd0, "shadow_src");
        pixel_x = 10'd101; title_on = 1'b0;
        step(EXP_SHADOW, 2'd0, "shadow_next");

        start_btn = 1'b1;
        step(12'h000, 2'd0, "start_latch");
        step(12'h000, 2'd0, "start_hold");
        frame(12'h000, 2'd1, "start_take");
        board_rgb = 12'h123;
        step(12'h123, 2'd1, "play_board");
        video_on = 1'b0;
        step(12'h000, 2'd1, "play_vid_off");
        video_on = 1'b1;

        board_ready = 1'b1; reset_req = 1'b1;
        step(12'h123, 2'd1, "req_latch");
        frame(12'h123, 2'd2, "enter_reset");
        resetting_on = 1'b1; board_rgb = 12'hEEE;
        for (int k = 1; k <= 60; k++) begin
            frame((((k - 1) / 16) % 2 == 0) ? 12'hFF0 : 12'h777,
                  (k < 60) ? 2'd2 : 2'd1, $sformatf("reset_frame%0d", k));
            if (k < 60) begin
                pixel_x = 10'd0;
                step(((k / 16) % 2 == 0) ? 12'hFF0 : 12'h777, 2'd2,
                     $sformatf("reset_mid%0d", k));
            end
        end
        step(12'hEEE, 2'd1, "exit_play");

        reset_n = 1'b0; resetting_on = 1'b0;
        step(12'h000, 2'd0, "async_rst");
        reset_n = 1'b1; title_on = 1'b1;
        step(12'hFF0, 2'd0, "post_rst_title");
        title_on = 1'b0;

        start_btn = 1'b1; reset_req = 1'b1; board_rgb = 12'h123;
        step(12'h000, 2'd0, "both_latch");
        frame(12'h000, 2'd1, "both_take");
        frame(12'h123, 2'd1, "no_reset1");
        frame(12'h123, 2'd1, "no_reset2");

        for (int i = 0; i < 5 && q_due.size() > 0; i++)
            @(negedge clk);
        if (q_due.size() > 0) begin
            $display("FAIL drain: %0d expectations left unchecked, want 0", q_due.size());
            bad   = bad + q_due.size();
            total = total + q_due.size();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
